id_ex_operand_stage: RTL and testbench
======================================

// Module: id_ex_operand_stage
// PURPOSE
// ID/EX pipeline register feeding the ALU: latches decoded fields, resolves RAW hazards by
//   forwarding from EX/MEM and MEM/WB, and muxes the final alu1/alu2 operands and alu_op.
// Sits between the decoder/register file and the ALU; also raises the load-use stall request.
// PARAMETERS
// XLEN       32  datapath width
// RA_W       5   register address width
// ALU_OP_W   4   ALU opcode width (ADD=0000 ... LUI=1010)
// PORTS
// clk_i          in   1        clock, rising edge
// rst_i          in   1        synchronous active-high reset
// stall_i        in   1        hold stage contents (from hazard/memory stall logic)
// flush_i        in   1        replace stage contents with a bubble (branch/jump redirect)
// id_valid_i     in   1        decode slot holds a real instruction
// id_pc_i        in   XLEN     instruction PC
// id_rs1_data_i  in   XLEN     register-file read data, rs1
// id_rs2_data_i  in   XLEN     register-file read data, rs2
// id_imm_i       in   XLEN     sign-extended immediate
// id_rs1_i       in   RA_W     rs1 index
// id_rs2_i       in   RA_W     rs2 index
// id_rd_i        in   RA_W     rd index
// id_alu_op_i    in   ALU_OP_W ALU opcode
// id_src1_pc_i   in   1        1: alu1 = PC, 0: alu1 = rs1
// id_src2_imm_i  in   1        1: alu2 = imm, 0: alu2 = rs2
// id_reg_write_i in   1        instruction writes rd
// id_mem_read_i  in   1        instruction is a load
// exm_rd_i       in   RA_W     EX/MEM destination index
// exm_wr_i       in   1        EX/MEM writes rd
// exm_data_i     in   XLEN     EX/MEM ALU result
// mwb_rd_i       in   RA_W     MEM/WB destination index
// mwb_wr_i       in   1        MEM/WB writes rd
// mwb_data_i     in   XLEN     MEM/WB writeback data
// load_use_o     out  1        request one-cycle stall of IF/ID (combinational)
// valid_o        out  1        EX slot holds a real instruction
// alu1_o         out  XLEN     ALU operand 1
// alu2_o         out  XLEN     ALU operand 2
// alu_op_o       out  ALU_OP_W ALU opcode
// store_data_o   out  XLEN     forwarded rs2 value (store data / branch compare)
// pc_o           out  XLEN     registered PC
// rd_o           out  RA_W     registered rd
// reg_write_o    out  1        registered write enable, forced 0 when !valid_o
// mem_read_o     out  1        registered load flag, forced 0 when !valid_o
// BEHAVIOUR
// - Reset: all registered state 0 -> valid_o=0, alu_op_o=0000 (ADD), alu1_o=alu2_o=0, rd_o=0.
// - Latency: 1 cycle; decode fields at edge N appear on outputs after edge N.
// - Priority per edge: rst_i > flush_i > stall_i > load. Flush during stall => bubble.
// - Bubble: valid, reg_write, mem_read cleared; alu_op=ADD; data fields don't-care (cleared).
// - Load: when !stall_i, capture id_* fields; valid = id_valid_i & !load_use_o
//   (a load-use hazard inserts a bubble while IF/ID holds).
// - Forwarding (combinational on registered rs1/rs2): fwd = exm match ? exm_data_i
//   : mwb match ? mwb_data_i : stored data; match = wr & rd==rs & rs!=0. EX/MEM wins ties.
// - Index 0 never forwarded; x0 operand is always the stored (zero) value.
// - Stall refresh: while stall_i & !flush_i, stored rs1/rs2 data are overwritten with the
//   forwarded values each cycle, so a producer leaving MEM/WB during the stall is not lost.
// - alu1_o = src1_pc ? pc : fwd_rs1;  alu2_o = src2_imm ? imm : fwd_rs2;  store_data_o = fwd_rs2.
// - load_use_o = valid_o & mem_read_o & rd_o!=0 & id_valid_i & (rd_o==id_rs1_i | rd_o==id_rs2_i).
//   Uses rs indices regardless of src select (conservative). Not gated by stall_i.
// - No arithmetic performed; all widths pass through unchanged.
// TESTING
// 1 Reset then idle: rst_i=1 for 2 cycles -> valid_o=0, alu_op_o=0000, reg_write_o=0.
// 2 ADD x3,x1,x2 (x1=5,x2=7, regfile) -> next cycle alu1_o=5, alu2_o=7, alu_op_o=0000, rd_o=3.
// 3 Fwd priority: rs1=4, exm rd=4 data=0x11, mwb rd=4 data=0x22 -> alu1_o=0x11; exm_wr_i=0 -> 0x22.
// 4 x0: rs1=0, exm rd=0 wr=1 data=0xFF -> alu1_o=0 (stored zero).
// 5 Load-use: EX holds lw x5, ID has add x6,x5,x1 -> load_use_o=1; next cycle valid_o=0.
// 6 Stall refresh: stall 2 cycles, mwb rd=rs2=9 data=0xAB in cycle 1 only -> alu2_o stays 0xAB.
//   Then flush_i=stall_i=1 -> bubble: valid_o=0, reg_write_o=0.

Source files
------------

// File: rtl/id_ex_operand_stage.sv
// ID/EX pipeline register: latches decoded fields, forwards from EX/MEM and MEM/WB,
// muxes the ALU operands and raises the load-use stall request.
module id_ex_operand_stage #(
  parameter int XLEN     = 32,
  parameter int RA_W     = 5,
  parameter int ALU_OP_W = 4
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                stall_i,
  input  logic                flush_i,
  input  logic                id_valid_i,
  input  logic [XLEN-1:0]     id_pc_i,
  input  logic [XLEN-1:0]     id_rs1_data_i,
  input  logic [XLEN-1:0]     id_rs2_data_i,
  input  logic [XLEN-1:0]     id_imm_i,
  input  logic [RA_W-1:0]     id_rs1_i,
  input  logic [RA_W-1:0]     id_rs2_i,
  input  logic [RA_W-1:0]     id_rd_i,
  input  logic [ALU_OP_W-1:0] id_alu_op_i,
  input  logic                id_src1_pc_i,
  input  logic                id_src2_imm_i,
  input  logic                id_reg_write_i,
  input  logic                id_mem_read_i,
  input  logic [RA_W-1:0]     exm_rd_i,
  input  logic                exm_wr_i,
  input  logic [XLEN-1:0]     exm_data_i,
  input  logic [RA_W-1:0]     mwb_rd_i,
  input  logic                mwb_wr_i,
  input  logic [XLEN-1:0]     mwb_data_i,
  output logic                load_use_o,
  output logic                valid_o,
  output logic [XLEN-1:0]     alu1_o,
  output logic [XLEN-1:0]     alu2_o,
  output logic [ALU_OP_W-1:0] alu_op_o,
  output logic [XLEN-1:0]     store_data_o,
  output logic [XLEN-1:0]     pc_o,
  output logic [RA_W-1:0]     rd_o,
  output logic                reg_write_o,
  output logic                mem_read_o
);

  localparam logic [ALU_OP_W-1:0] OP_ADD = '0;

  logic                valid_q,     valid_d;
  logic [XLEN-1:0]     pc_q,        pc_d;
  logic [XLEN-1:0]     rs1_data_q,  rs1_data_d;
  logic [XLEN-1:0]     rs2_data_q,  rs2_data_d;
  logic [XLEN-1:0]     imm_q,       imm_d;
  logic [RA_W-1:0]     rs1_q,       rs1_d;
  logic [RA_W-1:0]     rs2_q,       rs2_d;
  logic [RA_W-1:0]     rd_q,        rd_d;
  logic [ALU_OP_W-1:0] alu_op_q,    alu_op_d;
  logic                src1_pc_q,   src1_pc_d;
  logic                src2_imm_q,  src2_imm_d;
  logic                reg_write_q, reg_write_d;
  logic                mem_read_q,  mem_read_d;

  logic [XLEN-1:0] fwd_rs1, fwd_rs2;
  logic            load_use;

  // x0 is never a forwarding target; EX/MEM is the younger producer and wins ties
  always_comb begin
    fwd_rs1 = rs1_data_q;
    if (exm_wr_i && (exm_rd_i == rs1_q) && (rs1_q != '0))      fwd_rs1 = exm_data_i;
    else if (mwb_wr_i && (mwb_rd_i == rs1_q) && (rs1_q != '0)) fwd_rs1 = mwb_data_i;
    fwd_rs2 = rs2_data_q;
    if (exm_wr_i && (exm_rd_i == rs2_q) && (rs2_q != '0))      fwd_rs2 = exm_data_i;
    else if (mwb_wr_i && (mwb_rd_i == rs2_q) && (rs2_q != '0)) fwd_rs2 = mwb_data_i;
  end

  always_comb begin
    load_use = valid_q && mem_read_q && (rd_q != '0) && id_valid_i &&
               ((rd_q == id_rs1_i) || (rd_q == id_rs2_i));
  end

  always_comb begin
    valid_d     = valid_q;
    pc_d        = pc_q;
    rs1_data_d  = rs1_data_q;
    rs2_data_d  = rs2_data_q;
    imm_d       = imm_q;
    rs1_d       = rs1_q;
    rs2_d       = rs2_q;
    rd_d        = rd_q;
    alu_op_d    = alu_op_q;
    src1_pc_d   = src1_pc_q;
    src2_imm_d  = src2_imm_q;
    reg_write_d = reg_write_q;
    mem_read_d  = mem_read_q;
    if (flush_i) begin
      valid_d     = 1'b0;
      pc_d        = '0;
      rs1_data_d  = '0;
      rs2_data_d  = '0;
      imm_d       = '0;
      rs1_d       = '0;
      rs2_d       = '0;
      rd_d        = '0;
      alu_op_d    = OP_ADD;
      src1_pc_d   = 1'b0;
      src2_imm_d  = 1'b0;
      reg_write_d = 1'b0;
      mem_read_d  = 1'b0;
    end else if (stall_i) begin
      // keep capturing forwarded values so a producer retiring mid-stall is not lost
      rs1_data_d = fwd_rs1;
      rs2_data_d = fwd_rs2;
    end else begin
      valid_d     = id_valid_i && !load_use;
      pc_d        = id_pc_i;
      rs1_data_d  = id_rs1_data_i;
      rs2_data_d  = id_rs2_data_i;
      imm_d       = id_imm_i;
      rs1_d       = id_rs1_i;
      rs2_d       = id_rs2_i;
      rd_d        = id_rd_i;
      alu_op_d    = id_alu_op_i;
      src1_pc_d   = id_src1_pc_i;
      src2_imm_d  = id_src2_imm_i;
      reg_write_d = id_reg_write_i;
      mem_read_d  = id_mem_read_i;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      valid_q     <= 1'b0;
      pc_q        <= '0;
      rs1_data_q  <= '0;
      rs2_data_q  <= '0;
      imm_q       <= '0;
      rs1_q       <= '0;
      rs2_q       <= '0;
      rd_q        <= '0;
      alu_op_q    <= OP_ADD;
      src1_pc_q   <= 1'b0;
      src2_imm_q  <= 1'b0;
      reg_write_q <= 1'b0;
      mem_read_q  <= 1'b0;
    end else begin
      valid_q     <= valid_d;
      pc_q        <= pc_d;
      rs1_data_q  <= rs1_data_d;
      rs2_data_q  <= rs2_data_d;
      imm_q       <= imm_d;
      rs1_q       <= rs1_d;
      rs2_q       <= rs2_d;
      rd_q        <= rd_d;
      alu_op_q    <= alu_op_d;
      src1_pc_q   <= src1_pc_d;
      src2_imm_q  <= src2_imm_d;
      reg_write_q <= reg_write_d;
      mem_read_q  <= mem_read_d;
    end
  end

  assign load_use_o   = load_use;
  assign valid_o      = valid_q;
  assign alu1_o       = src1_pc_q ? pc_q : fwd_rs1;
  assign alu2_o       = src2_imm_q ? imm_q : fwd_rs2;
  assign alu_op_o     = alu_op_q;
  assign store_data_o = fwd_rs2;
  assign pc_o         = pc_q;
  assign rd_o         = rd_q;
  assign reg_write_o  = valid_q && reg_write_q;
  assign mem_read_o   = valid_q && mem_read_q;

endmodule

// File: tb/tb_id_ex_operand_stage.sv
// Bench for id_ex_operand_stage: directed vector table, hazard sequences, and
// randomized traffic against a behavioural model of the EX slot.
module tb_id_ex_operand_stage;

  logic        clk_i = 1'b0;
  logic        rst_i, stall_i, flush_i, id_valid_i;
  logic [31:0] id_pc_i, id_rs1_data_i, id_rs2_data_i, id_imm_i;
  logic [4:0]  id_rs1_i, id_rs2_i, id_rd_i;
  logic [3:0]  id_alu_op_i;
  logic        id_src1_pc_i, id_src2_imm_i, id_reg_write_i, id_mem_read_i;
  logic [4:0]  exm_rd_i, mwb_rd_i;
  logic        exm_wr_i, mwb_wr_i;
  logic [31:0] exm_data_i, mwb_data_i;
  logic        load_use_o, valid_o, reg_write_o, mem_read_o;
  logic [31:0] alu1_o, alu2_o, store_data_o, pc_o;
  logic [3:0]  alu_op_o;
  logic [4:0]  rd_o;

  int errors = 0;
  int checks = 0;

  id_ex_operand_stage dut (
    .clk_i(clk_i), .rst_i(rst_i), .stall_i(stall_i), .flush_i(flush_i),
    .id_valid_i(id_valid_i), .id_pc_i(id_pc_i), .id_rs1_data_i(id_rs1_data_i),
    .id_rs2_data_i(id_rs2_data_i), .id_imm_i(id_imm_i), .id_rs1_i(id_rs1_i),
    .id_rs2_i(id_rs2_i), .id_rd_i(id_rd_i), .id_alu_op_i(id_alu_op_i),
    .id_src1_pc_i(id_src1_pc_i), .id_src2_imm_i(id_src2_imm_i),
    .id_reg_write_i(id_reg_write_i), .id_mem_read_i(id_mem_read_i),
    .exm_rd_i(exm_rd_i), .exm_wr_i(exm_wr_i), .exm_data_i(exm_data_i),
    .mwb_rd_i(mwb_rd_i), .mwb_wr_i(mwb_wr_i), .mwb_data_i(mwb_data_i),
    .load_use_o(load_use_o), .valid_o(valid_o), .alu1_o(alu1_o), .alu2_o(alu2_o),
    .alu_op_o(alu_op_o), .store_data_o(store_data_o), .pc_o(pc_o), .rd_o(rd_o),
    .reg_write_o(reg_write_o), .mem_read_o(mem_read_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic idle_inputs();
    rst_i = 0; stall_i = 0; flush_i = 0; id_valid_i = 0;
    id_pc_i = 0; id_rs1_data_i = 0; id_rs2_data_i = 0; id_imm_i = 0;
    id_rs1_i = 0; id_rs2_i = 0; id_rd_i = 0; id_alu_op_i = 0;
    id_src1_pc_i = 0; id_src2_imm_i = 0; id_reg_write_i = 0; id_mem_read_i = 0;
    exm_rd_i = 0; exm_wr_i = 0; exm_data_i = 0;
    mwb_rd_i = 0; mwb_wr_i = 0; mwb_data_i = 0;
  endtask

  typedef struct {
    logic        valid;
    logic [31:0] pc, rs1d, rs2d, imm;
    logic [4:0]  rs1, rs2, rd;
    logic [3:0]  op;
    logic        s1pc, s2imm, rw;
    logic [4:0]  exm_rd;
    logic        exm_wr;
    logic [31:0] exm_data;
    logic [4:0]  mwb_rd;
    logic        mwb_wr;
    logic [31:0] mwb_data;
    logic [31:0] e_alu1, e_alu2, e_store;
    logic        e_valid, e_rw;
  } vec_t;

  // Behavioural view of the instruction sitting in EX
  typedef struct {
    logic        valid;
    logic [31:0] pc, a, b, imm;
    logic [4:0]  rs1, rs2, rd;
    logic [3:0]  op;
    logic        s1pc, s2imm, rw, mr;
  } slot_t;

  slot_t m;

  function automatic logic [31:0] resolve(input logic [4:0] idx, input logic [31:0] stored);
    if (idx == 0) return stored;
    if (exm_wr_i && exm_rd_i == idx) return exm_data_i;
    if (mwb_wr_i && mwb_rd_i == idx) return mwb_data_i;
    return stored;
  endfunction

  function automatic logic model_load_use();
    return m.valid && m.mr && m.rd != 0 && id_valid_i &&
           (m.rd == id_rs1_i || m.rd == id_rs2_i);
  endfunction

  function automatic slot_t model_next();
    slot_t n;
    n = m;
    if (rst_i || flush_i) begin
      n = '{default: '0};
    end else if (stall_i) begin
      n.a = resolve(m.rs1, m.a);
      n.b = resolve(m.rs2, m.b);
    end else begin
      n.valid = id_valid_i && !model_load_use();
      n.pc = id_pc_i; n.a = id_rs1_data_i; n.b = id_rs2_data_i; n.imm = id_imm_i;
      n.rs1 = id_rs1_i; n.rs2 = id_rs2_i; n.rd = id_rd_i; n.op = id_alu_op_i;
      n.s1pc = id_src1_pc_i; n.s2imm = id_src2_imm_i;
      n.rw = id_reg_write_i; n.mr = id_mem_read_i;
    end
    return n;
  endfunction

  task automatic check_model();
    logic [31:0] f1, f2;
    f1 = resolve(m.rs1, m.a);
    f2 = resolve(m.rs2, m.b);
    check("rnd_valid", 32'(valid_o), 32'(m.valid));
    check("rnd_alu1", alu1_o, m.s1pc ? m.pc : f1);
    check("rnd_alu2", alu2_o, m.s2imm ? m.imm : f2);
    check("rnd_store", store_data_o, f2);
    check("rnd_op", 32'(alu_op_o), 32'(m.op));
    check("rnd_pc", pc_o, m.pc);
    check("rnd_rd", 32'(rd_o), 32'(m.rd));
    check("rnd_rw", 32'(reg_write_o), 32'(m.valid && m.rw));
    check("rnd_mr", 32'(mem_read_o), 32'(m.valid && m.mr));
    check("rnd_load_use", 32'(load_use_o), 32'(model_load_use()));
  endtask

  vec_t vecs[6];

  initial begin
    vecs[0] = '{1,32'h100,5,7,0, 1,2,3, 4'h0,0,0,1, 0,0,0, 0,0,0,
                5,7,7, 1,1};
    vecs[1] = '{1,32'h104,32'h99,3,0, 4,2,7, 4'h1,0,0,1, 4,1,32'h11, 4,1,32'h22,
                32'h11,3,3, 1,1};
    vecs[2] = '{1,32'h108,32'h99,3,0, 4,2,7, 4'h2,0,0,1, 4,0,32'h11, 4,1,32'h22,
                32'h22,3,3, 1,1};
    vecs[3] = '{1,32'h10C,0,0,0, 0,0,8, 4'h3,0,0,1, 0,1,32'hFF, 0,1,32'hEE,
                0,0,0, 1,1};
    vecs[4] = '{1,32'h2000,1,32'h55,32'hFFFF_FFF0, 2,6,9, 4'hA,1,1,0, 0,0,0, 6,1,32'h66,
                32'h2000,32'hFFFF_FFF0,32'h66, 1,0};
    vecs[5] = '{0,32'h300,32'h12,32'h34,0, 3,5,10, 4'h5,0,0,1, 0,0,0, 0,0,0,
                32'h12,32'h34,32'h34, 0,0};

    idle_inputs();

    // reset then idle
    rst_i = 1;
    id_valid_i = 1; id_alu_op_i = 4'h7; id_rd_i = 5; id_reg_write_i = 1; id_rs1_data_i = 32'hDEAD;
    tick(); tick();
    check("reset_valid", 32'(valid_o), 0);
    check("reset_op", 32'(alu_op_o), 0);
    check("reset_rw", 32'(reg_write_o), 0);
    check("reset_alu1", alu1_o, 0);
    check("reset_alu2", alu2_o, 0);
    check("reset_rd", 32'(rd_o), 0);
    idle_inputs();

    foreach (vecs[i]) begin
      id_valid_i = vecs[i].valid; id_pc_i = vecs[i].pc;
      id_rs1_data_i = vecs[i].rs1d; id_rs2_data_i = vecs[i].rs2d; id_imm_i = vecs[i].imm;
      id_rs1_i = vecs[i].rs1; id_rs2_i = vecs[i].rs2; id_rd_i = vecs[i].rd;
      id_alu_op_i = vecs[i].op; id_src1_pc_i = vecs[i].s1pc; id_src2_imm_i = vecs[i].s2imm;
      id_reg_write_i = vecs[i].rw; id_mem_read_i = 0;
      exm_wr_i = 0; mwb_wr_i = 0;
      tick();
      exm_rd_i = vecs[i].exm_rd; exm_wr_i = vecs[i].exm_wr; exm_data_i = vecs[i].exm_data;
      mwb_rd_i = vecs[i].mwb_rd; mwb_wr_i = vecs[i].mwb_wr; mwb_data_i = vecs[i].mwb_data;
      #1;
      check($sformatf("vec%0d_alu1", i), alu1_o, vecs[i].e_alu1);
      check($sformatf("vec%0d_alu2", i), alu2_o, vecs[i].e_alu2);
      check($sformatf("vec%0d_store", i), store_data_o, vecs[i].e_store);
      check($sformatf("vec%0d_valid", i), 32'(valid_o), 32'(vecs[i].e_valid));
      check($sformatf("vec%0d_rw", i), 32'(reg_write_o), 32'(vecs[i].e_rw));
      check($sformatf("vec%0d_op", i), 32'(alu_op_o), 32'(vecs[i].op));
      check($sformatf("vec%0d_rd", i), 32'(rd_o), 32'(vecs[i].rd));
    end
    idle_inputs();

    // load-use: lw x5 in EX, add x6,x5,x1 in ID
    id_valid_i = 1; id_rd_i = 5; id_mem_read_i = 1; id_reg_write_i = 1; id_rs1_i = 2;
    tick();
    check("lu_ex_memread", 32'(mem_read_o), 1);
    id_rd_i = 6; id_mem_read_i = 0; id_rs1_i = 5; id_rs2_i = 1;
    #1;
    check("lu_request", 32'(load_use_o), 1);
    tick();
    check("lu_bubble_valid", 32'(valid_o), 0);
    check("lu_bubble_rw", 32'(reg_write_o), 0);
    check("lu_cleared", 32'(load_use_o), 0);
    tick();
    check("lu_retry_valid", 32'(valid_o), 1);
    check("lu_retry_rd", 32'(rd_o), 6);
    idle_inputs();

    // stall refresh: producer for rs2=x9 visible in MEM/WB for one stalled cycle only
    id_valid_i = 1; id_rs2_i = 9; id_rs2_data_i = 32'h01; id_rd_i = 4; id_reg_write_i = 1;
    tick();
    check("st_pre_alu2", alu2_o, 32'h01);
    stall_i = 1; id_rs2_data_i = 32'h77; id_rd_i = 12;
    mwb_rd_i = 9; mwb_wr_i = 1; mwb_data_i = 32'hAB;
    #1;
    check("st_fwd_alu2", alu2_o, 32'hAB);
    tick();
    mwb_wr_i = 0;
    #1;
    check("st_hold_alu2", alu2_o, 32'hAB);
    check("st_hold_rd", 32'(rd_o), 4);
    tick();
    check("st_hold2_alu2", alu2_o, 32'hAB);
    check("st_hold2_valid", 32'(valid_o), 1);
    flush_i = 1;
    tick();
    check("st_flush_valid", 32'(valid_o), 0);
    check("st_flush_rw", 32'(reg_write_o), 0);
    check("st_flush_op", 32'(alu_op_o), 0);
    idle_inputs();

    // randomized traffic against the slot model
    rst_i = 1;
    tick();
    m = '{default: '0};
    rst_i = 0;
    for (int c = 0; c < 400; c++) begin
      slot_t nxt;
      rst_i = ($urandom_range(0, 49) == 0);
      flush_i = ($urandom_range(0, 11) == 0);
      stall_i = ($urandom_range(0, 4) == 0);
      id_valid_i = ($urandom_range(0, 5) != 0);
      id_pc_i = $urandom; id_rs1_data_i = $urandom; id_rs2_data_i = $urandom; id_imm_i = $urandom;
      id_rs1_i = 5'($urandom_range(0, 7)); id_rs2_i = 5'($urandom_range(0, 7));
      id_rd_i = 5'($urandom_range(0, 7)); id_alu_op_i = 4'($urandom_range(0, 10));
      id_src1_pc_i = 1'($urandom); id_src2_imm_i = 1'($urandom);
      id_reg_write_i = 1'($urandom); id_mem_read_i = ($urandom_range(0, 2) == 0);
      exm_rd_i = 5'($urandom_range(0, 7)); exm_wr_i = 1'($urandom); exm_data_i = $urandom;
      mwb_rd_i = 5'($urandom_range(0, 7)); mwb_wr_i = 1'($urandom); mwb_data_i = $urandom;
      #1;
      check_model();
      nxt = model_next();
      tick();
      m = nxt;
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
